// File: rtl/rb2_arb_pkg.sv
// Shared definitions for the RB2 register-bank arbiter: FSM state encoding,
// default bank geometry and the port identifiers used by the grant logic.
package rb2_arb_pkg;

    localparam int RB2_ADDR_W = 3;
    localparam int RB2_DATA_W = 18;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_ACK     = 3'd4
    } state_e;

endpackage

// File: rtl/rb2_rr_pick.sv
// Two-way round-robin picker. A lone request wins outright; on a tie the port
// that did not win last time is granted. Purely combinational.
module rb2_rr_pick
    import rb2_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic rr_last,
    output logic grant,
    output logic valid
);

    // Grant selection: tie goes to the port opposite rr_last.
    always_comb begin
        valid = a_req | b_req;
        grant = PORT_A;
        if (a_req && b_req) begin
            grant = (rr_last == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/rb2_arbiter.sv
// RB2 arbiter: shares the single-port 8x18 bank RB2 between port A and port B.
// Each access runs IDLE -> ACCESS -> (CAPTURE for reads) -> ACK -> IDLE.
// Handshake: a request is a level sampled only in IDLE; rw/addr/wdata need
// only be valid in that sampling cycle. Completion is a one-cycle ack pulse,
// with rdata valid alongside it for reads.
// Optional build macro RB2_VERIFY_EN: read back every write through a VERIFY
// state, retrying up to MAX_RETRY times and raising sticky err on failure.
module rb2_arbiter
    import rb2_arb_pkg::*;
#(
    parameter int ADDR_W    = RB2_ADDR_W,
    parameter int DATA_W    = RB2_DATA_W,
    parameter int WR_TOTAL  = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              all_done,
    output logic              err,
    output state_e            dbg_state
);

    localparam int CNT_W = $clog2(WR_TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WR_TOTAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_TOTAL - 1);

    if (MAX_RETRY < 1 || WR_TOTAL < 1) begin : g_bad_param
        $error("rb2_arbiter: MAX_RETRY and WR_TOTAL must be at least 1");
    end

    logic              pick_grant;
    logic              pick_valid;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    state_e            state;
    logic              win;
    logic              rr_last;
    logic              lat_rw;
    logic              commit;
    logic [CNT_W-1:0]  wr_cnt;

`ifdef RB2_VERIFY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry;
    logic               vfy_phase;
`else
    assign err = 1'b0;
`endif

    rb2_rr_pick u_pick (
        .a_req   (a_req),
        .b_req   (b_req),
        .rr_last (rr_last),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    // Route the winning requester's command fields toward the latch stage.
    always_comb begin
        sel_rw    = a_rw;
        sel_addr  = a_addr;
        sel_wdata = a_wdata;
        if (pick_grant == PORT_B) begin
            sel_rw    = b_rw;
            sel_addr  = b_addr;
            sel_wdata = b_wdata;
        end
    end

    assign dbg_state = state;

    // Access sequencer; RB2_A/RB2_D double as the latched address and write data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            win      <= PORT_A;
            rr_last  <= PORT_B;
            lat_rw   <= 1'b1;
            commit   <= 1'b0;
            wr_cnt   <= '0;
            RB2_RW   <= 1'b1;
            RB2_A    <= '0;
            RB2_D    <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            all_done <= 1'b0;
`ifdef RB2_VERIFY_EN
            retry     <= '0;
            vfy_phase <= 1'b0;
            err       <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    RB2_RW <= 1'b1;
                    if (pick_valid) begin
                        win     <= pick_grant;
                        rr_last <= pick_grant;
                        lat_rw  <= sel_rw;
                        RB2_RW  <= sel_rw;
                        RB2_A   <= sel_addr;
                        RB2_D   <= sel_wdata;
`ifdef RB2_VERIFY_EN
                        retry   <= '0;
`endif
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    RB2_RW <= 1'b1;
                    if (lat_rw) begin
                        state <= ST_CAPTURE;
                    end else begin
`ifdef RB2_VERIFY_EN
                        vfy_phase <= 1'b0;
                        state     <= ST_VERIFY;
`else
                        a_ack  <= (win == PORT_A);
                        b_ack  <= (win == PORT_B);
                        commit <= 1'b1;
                        state  <= ST_ACK;
`endif
                    end
                end
                ST_CAPTURE: begin
                    RB2_RW <= 1'b1;
                    if (win == PORT_A) begin
                        a_rdata <= RB2_Q;
                    end else begin
                        b_rdata <= RB2_Q;
                    end
                    a_ack  <= (win == PORT_A);
                    b_ack  <= (win == PORT_B);
                    commit <= 1'b0;
                    state  <= ST_ACK;
                end
`ifdef RB2_VERIFY_EN
                ST_VERIFY: begin
                    RB2_RW <= 1'b1;
                    if (!vfy_phase) begin
                        vfy_phase <= 1'b1;
                    end else if (RB2_Q == RB2_D) begin
                        a_ack  <= (win == PORT_A);
                        b_ack  <= (win == PORT_B);
                        commit <= 1'b1;
                        state  <= ST_ACK;
                    end else if (retry < RETRY_MAX) begin
                        retry  <= retry + 1'b1;
                        RB2_RW <= 1'b0;
                        state  <= ST_ACCESS;
                    end else begin
                        err    <= 1'b1;
                        a_ack  <= (win == PORT_A);
                        b_ack  <= (win == PORT_B);
                        commit <= 1'b0;
                        state  <= ST_ACK;
                    end
                end
`endif
                ST_ACK: begin
                    RB2_RW <= 1'b1;
                    if (commit && wr_cnt != CNT_MAX) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == CNT_LAST) begin
                            all_done <= 1'b1;
                        end
                    end
                    commit <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    RB2_RW <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb2_arbiter.sv
// Bench for rb2_arbiter: a behavioural RB2 macro, a directed vector table,
// continuous-contention, reset-abort and write-count sequences, and random
// transactions checked against a transaction-order reference model.
module tb_rb2_arbiter;
    import rb2_arb_pkg::*;

    localparam int WR_TOTAL = 8;
`ifdef RB2_VERIFY_EN
    localparam int LAT_W = 4;
`else
    localparam int LAT_W = 2;
`endif
    localparam int LAT_R = 3;

    typedef struct packed {
        logic        a_on;
        logic        a_rw;
        logic [2:0]  a_addr;
        logic [17:0] a_wd;
        logic        b_on;
        logic        b_rw;
        logic [2:0]  b_addr;
        logic [17:0] b_wd;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic        exp_first;
        logic [17:0] exp_ard;
        logic [17:0] exp_brd;
    } tv_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_rw, b_req, b_rw;
    logic [2:0]  a_addr, b_addr;
    logic [17:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [17:0] a_rdata, b_rdata;
    logic        RB2_RW;
    logic [2:0]  RB2_A;
    logic [17:0] RB2_D, RB2_Q;
    logic        all_done, err;
    state_e      dbg_state;

    always #5 clk = ~clk;

    rb2_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_rw      (a_rw),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_rw      (b_rw),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .RB2_RW    (RB2_RW),
        .RB2_A     (RB2_A),
        .RB2_D     (RB2_D),
        .RB2_Q     (RB2_Q),
        .all_done  (all_done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- RB2 macro model ----------------
    logic [17:0] rb2_mem [8];
    logic        mem_clr;
    logic        q_bad;
    int          strobes = 0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) rb2_mem[i] <= '0;
        end else if (!RB2_RW) begin
            rb2_mem[RB2_A] <= RB2_D;
        end
    end

    always @(posedge clk) begin
        if (!RB2_RW) strobes <= strobes + 1;
    end

    assign RB2_Q = rb2_mem[RB2_A] ^ {17'd0, q_bad};

    // ---------------- scoreboard / reference model ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] ref_mem [8];
    logic        rr_m;
    int          wcnt_m;
    logic [17:0] ard_m, brd_m;
    logic        err_m;
    logic [17:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        rr_m   = PORT_B;
        wcnt_m = 0;
        ard_m  = '0;
        brd_m  = '0;
        err_m  = 1'b0;
    endtask

    // Service order and read results from the arbitration rules applied to a copy of the memory.
    function automatic void predict(input vec_t v, output logic first,
                                    output logic [17:0] ard, output logic [17:0] brd);
        logic [17:0] m [8];
        logic        p;
        m     = ref_mem;
        first = (v.a_on && v.b_on) ? ~rr_m : (v.a_on ? PORT_A : PORT_B);
        ard   = '0;
        brd   = '0;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : ~first;
            if (p == PORT_A && v.a_on) begin
                if (v.a_rw) ard = m[v.a_addr];
                else        m[v.a_addr] = v.a_wd;
            end
            if (p == PORT_B && v.b_on) begin
                if (v.b_rw) brd = m[v.b_addr];
                else        m[v.b_addr] = v.b_wd;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_vec(input vec_t v, input logic exp_first,
                           input logic [17:0] exp_ard, input logic [17:0] exp_brd);
        logic pend_a, pend_b, exp_port, prw, served;
        int   lat, s0, n_w;
        s0  = strobes;
        n_w = ((v.a_on && !v.a_rw) ? 1 : 0) + ((v.b_on && !v.b_rw) ? 1 : 0);
        check("idle_before", dbg_state, ST_IDLE);
        a_req = v.a_on; a_rw = v.a_rw; a_addr = v.a_addr; a_wdata = v.a_wd;
        b_req = v.b_on; b_rw = v.b_rw; b_addr = v.b_addr; b_wdata = v.b_wd;
        pend_a = v.a_on; pend_b = v.b_on; served = 1'b0; lat = 0;
        while ((pend_a || pend_b) && lat <= 20) begin
            @(negedge clk);
            lat++;
            check("all_done", all_done, (wcnt_m >= WR_TOTAL));
            if (a_ack || b_ack) begin
                check("one_ack", a_ack & b_ack, 0);
                exp_port = (pend_a && pend_b) ? exp_first : (pend_a ? PORT_A : PORT_B);
                check("grant", b_ack, exp_port);
                prw = (exp_port == PORT_B) ? v.b_rw : v.a_rw;
                check("latency", lat, (served ? 1 : 0) + (prw ? LAT_R : LAT_W));
                if (exp_port == PORT_A) begin
                    if (v.a_rw) ard_m = exp_ard;
                    else begin ref_mem[v.a_addr] = v.a_wd; wcnt_m++; end
                    exp_q.push_back(ard_m);
                    check("a_rdata", a_rdata, exp_q.pop_front());
                    pend_a = 1'b0; a_req = 1'b0;
                end else begin
                    if (v.b_rw) brd_m = exp_brd;
                    else begin ref_mem[v.b_addr] = v.b_wd; wcnt_m++; end
                    exp_q.push_back(brd_m);
                    check("b_rdata", b_rdata, exp_q.pop_front());
                    pend_b = 1'b0; b_req = 1'b0;
                end
                rr_m = exp_port; served = 1'b1; lat = 0;
            end
        end
        if (pend_a || pend_b) check("ack_timeout", lat, 0);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("all_done_after", all_done, (wcnt_m >= WR_TOTAL));
        check("write_strobes", strobes - s0, n_w);
    endtask

    // Both ports request reads continuously; grants must alternate.
    task automatic run_stream(input int n);
        logic exp_p;
        int   served, lat;
        a_addr = 3'($urandom_range(0, 7)); b_addr = 3'($urandom_range(0, 7));
        a_rw = 1'b1; b_rw = 1'b1; a_req = 1'b1; b_req = 1'b1;
        exp_p = ~rr_m; served = 0; lat = 0;
        while (served < n && lat <= 20) begin
            @(negedge clk);
            lat++;
            if (a_ack || b_ack) begin
                check("rr_one_ack", a_ack & b_ack, 0);
                check("rr_port", b_ack, exp_p);
                check("rr_gap", lat, (served == 0) ? LAT_R : LAT_R + 1);
                if (exp_p == PORT_A) begin
                    ard_m = ref_mem[a_addr];
                    check("rr_a_rdata", a_rdata, ard_m);
                end else begin
                    brd_m = ref_mem[b_addr];
                    check("rr_b_rdata", b_rdata, brd_m);
                end
                rr_m = exp_p; exp_p = ~exp_p; served++; lat = 0;
                if (served == n) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        check("rr_served", served, n);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
    endtask

`ifdef RB2_VERIFY_EN
    // Macro returns corrupted data: expect 4 write attempts, err, an uncounted ack.
    task automatic run_verify_fail();
        int lat, s0;
        s0 = strobes; lat = 0; q_bad = 1'b1;
        a_req = 1'b1; a_rw = 1'b0; a_addr = 3'd4; a_wdata = 18'h0F0F0;
        while (!a_ack && lat <= 30) begin
            @(negedge clk);
            lat++;
        end
        check("vfy_ack", a_ack, 1);
        check("vfy_latency", lat, 13);
        check("vfy_err", err, 1);
        check("vfy_strobes", strobes - s0, 4);
        a_req = 1'b0; q_bad = 1'b0;
        ref_mem[4] = 18'h0F0F0; err_m = 1'b1;
        @(negedge clk);
        check("vfy_all_done", all_done, (wcnt_m >= WR_TOTAL));
    endtask
`endif

    // ---------------- test sequence ----------------
    tv_t  tbl [9];
    vec_t rv;
    logic pf;
    logic [17:0] pa, pb;
    int   s_abort;

    initial begin
        rst = 1'b0; mem_clr = 1'b1; q_bad = 1'b0;
        a_req = 1'b0; a_rw = 1'b1; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_rw = 1'b1; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        model_reset();

        //            a_on  a_rw  a_addr a_wd        b_on  b_rw  b_addr b_wd        first ard        brd
        tbl[0] = '{'{1'b1, 1'b0, 3'd5, 18'h2A5A5, 1'b0, 1'b0, 3'd0, 18'h00000}, 1'b0, 18'h0,     18'h0    };
        tbl[1] = '{'{1'b0, 1'b0, 3'd0, 18'h00000, 1'b1, 1'b1, 3'd5, 18'h00000}, 1'b1, 18'h0,     18'h2A5A5};
        tbl[2] = '{'{1'b1, 1'b0, 3'd1, 18'h11111, 1'b1, 1'b0, 3'd2, 18'h22222}, 1'b0, 18'h0,     18'h0    };
        tbl[3] = '{'{1'b1, 1'b1, 3'd2, 18'h00000, 1'b1, 1'b1, 3'd1, 18'h00000}, 1'b0, 18'h22222, 18'h11111};
        tbl[4] = '{'{1'b1, 1'b1, 3'd5, 18'h00000, 1'b1, 1'b0, 3'd5, 18'h3FFFF}, 1'b0, 18'h2A5A5, 18'h0    };
        tbl[5] = '{'{1'b0, 1'b0, 3'd0, 18'h00000, 1'b1, 1'b1, 3'd5, 18'h00000}, 1'b1, 18'h0,     18'h3FFFF};
        tbl[6] = '{'{1'b1, 1'b0, 3'd0, 18'h0ABCD, 1'b1, 1'b1, 3'd0, 18'h00000}, 1'b0, 18'h0,     18'h0ABCD};
        tbl[7] = '{'{1'b1, 1'b0, 3'd3, 18'h12345, 1'b0, 1'b0, 3'd0, 18'h00000}, 1'b0, 18'h0,     18'h0    };
        tbl[8] = '{'{1'b1, 1'b1, 3'd3, 18'h00000, 1'b1, 1'b1, 3'd5, 18'h00000}, 1'b1, 18'h12345, 18'h3FFFF};

        repeat (3) @(negedge clk);
        check("rst_rb2_rw", RB2_RW, 1);
        check("rst_rb2_a", RB2_A, 0);
        check("rst_rb2_d", RB2_D, 0);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_flags", {all_done, err}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        mem_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i].v, tbl[i].exp_first, tbl[i].exp_ard, tbl[i].exp_brd);
        end
        for (int i = 0; i < 8; i++) check("mem_directed", rb2_mem[i], ref_mem[i]);

        run_stream(6);

        // Reset while a write is in its ACCESS cycle.
        a_req = 1'b1; a_rw = 1'b0; a_addr = 3'd6; a_wdata = 18'h15555;
        @(negedge clk);
        check("abort_pre_rw", RB2_RW, 0);
        s_abort = strobes;
        #1 rst = 1'b0;
        #1;
        check("abort_rw", RB2_RW, 1);
        check("abort_state", dbg_state, ST_IDLE);
        a_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ack", {a_ack, b_ack}, 0);
        end
        check("abort_strobes", strobes - s_abort, 0);
        check("abort_rdata", a_rdata, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);

        // WR_TOTAL + 1 writes from A, addresses 0..7 then 0 again.
        for (int i = 0; i < WR_TOTAL + 1; i++) begin
            rv = '0;
            rv.a_on = 1'b1; rv.a_rw = 1'b0; rv.a_addr = 3'(i); rv.a_wd = 18'($urandom);
            run_vec(rv, PORT_A, '0, '0);
        end
        check("all_done_sticky", all_done, 1);

        for (int n = 0; n < 60; n++) begin
            rv.a_on = 1'($urandom_range(0, 1));   rv.b_on = 1'($urandom_range(0, 1));
            rv.a_rw = 1'($urandom_range(0, 1));   rv.b_rw = 1'($urandom_range(0, 1));
            rv.a_addr = 3'($urandom_range(0, 7)); rv.b_addr = 3'($urandom_range(0, 7));
            rv.a_wd = 18'($urandom);              rv.b_wd = 18'($urandom);
            if (!rv.a_on && !rv.b_on) rv.a_on = 1'b1;
            predict(rv, pf, pa, pb);
            run_vec(rv, pf, pa, pb);
        end

`ifdef RB2_VERIFY_EN
        run_verify_fail();
`endif

        for (int i = 0; i < 8; i++) check("mem_final", rb2_mem[i], ref_mem[i]);
        check("err_final", err, err_m);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
